// File: rtl/ddr_rd_arbiter_if.sv
// ddr_rd_arbiter_if: client-side and DDR-side buses of the DDR read arbiter.
// master = the arbiter; slave = its environment (clients plus DDR read master).
interface ddr_rd_arbiter_if;
   logic [3:0]   cl_req;
   logic [3:0]   cl_ack;
   logic [3:0]   cl_vout;
   logic [127:0] cl_dout;
   logic [3:0]   cl_vin;
   logic [31:0]  cl_din;
   logic         m_cmd_valid;
   logic         m_cmd_ready;
   logic [31:0]  m_cmd_addr;
   logic [8:0]   m_cmd_len;
   logic         m_rd_valid;
   logic [31:0]  m_rd_data;
   logic         m_rd_last;
   modport master (
      input  cl_req, cl_vout, cl_dout, m_cmd_ready, m_rd_valid, m_rd_data, m_rd_last,
      output cl_ack, cl_vin, cl_din, m_cmd_valid, m_cmd_addr, m_cmd_len
   );
   modport slave (
      output cl_req, cl_vout, cl_dout, m_cmd_ready, m_rd_valid, m_rd_data, m_rd_last,
      input  cl_ack, cl_vin, cl_din, m_cmd_valid, m_cmd_addr, m_cmd_len
   );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: 4-client round-robin arbiter serialising read commands onto one DDR read master.
// Optional DDR_RD_ARB_TIMEOUT_EN: abandon a grant whose command words stall for 256 cycles.
module ddr_rd_arbiter (
   input  logic             clk,
   input  logic             rst,
   ddr_rd_arbiter_if.master bus,
   output logic [1:0]       err_flags
);
   typedef enum logic [2:0] {IDLE, ADDR, LEN, CMD, DATA, DONE} state_t;
   state_t      state, state_nx;
   logic [1:0]  g, rr_ptr, win;
   logic [8:0]  cnt;
   logic [31:0] word_g;
   logic        any_req, vout_g, wait_word, beat, tmo_hit;
   assign any_req   = |bus.cl_req;
   assign vout_g    = bus.cl_vout[g];
   assign word_g    = bus.cl_dout[{g, 5'd0} +: 32];
   assign wait_word = state == ADDR || state == LEN;
   assign beat      = state == DATA && bus.m_rd_valid;
`ifdef DDR_RD_ARB_TIMEOUT_EN
   logic [7:0] tmo;
   always_ff @(posedge clk or posedge rst)
      if (rst) tmo <= 8'd0;
      else     tmo <= (wait_word && !vout_g) ? tmo + 8'd1 : 8'd0;
   assign tmo_hit = tmo == 8'hff;
`else
   assign tmo_hit = 1'b0;
`endif
   // descending scan so the lowest offset from rr_ptr wins
   always_comb begin
      win = rr_ptr;
      for (int k = 3; k >= 0; k--)
         if (bus.cl_req[rr_ptr + 2'(k)]) win = rr_ptr + 2'(k);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = any_req ? ADDR : IDLE;
         ADDR:    state_nx = vout_g ? LEN : (tmo_hit ? DONE : ADDR);
         LEN:     state_nx = vout_g ? CMD : (tmo_hit ? DONE : LEN);
         CMD:     state_nx = bus.m_cmd_ready ? DATA : CMD;
         DATA:    state_nx = (bus.m_rd_valid && cnt == 9'd1) ? DONE : DATA;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.cl_ack      = (state inside {ADDR, LEN, CMD, DATA}) ? 4'b1 << g : 4'b0;
      bus.m_cmd_valid = state == CMD;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         g              <= 2'd0;
         rr_ptr         <= 2'd0;
         cnt            <= 9'd0;
         bus.m_cmd_addr <= 32'd0;
         bus.m_cmd_len  <= 9'd0;
         bus.cl_vin     <= 4'b0;
         bus.cl_din     <= 32'd0;
         err_flags      <= 2'b0;
      end else begin
         bus.cl_vin <= beat ? 4'b1 << g : 4'b0;
         if (beat) bus.cl_din <= bus.m_rd_data;
         if (state == IDLE && any_req) begin
            g      <= win;
            rr_ptr <= win + 2'd1;
         end
         if (state == ADDR && vout_g) bus.m_cmd_addr <= {word_g[31:2], 2'b00};
         // a zero length field encodes the full 256-beat burst
         if (state == LEN && vout_g) bus.m_cmd_len <= {word_g[7:0] == 8'd0, word_g[7:0]};
         if (state == CMD && bus.m_cmd_ready) cnt <= bus.m_cmd_len;
         if (beat) cnt <= cnt - 9'd1;
         if (beat && (bus.m_rd_last != (cnt == 9'd1))) err_flags[0] <= 1'b1;
         if (wait_word && !vout_g && tmo_hit) err_flags[1] <= 1'b1;
      end
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed vector table, reset/timeout sequences and random transactions
// checked against a transaction-level round-robin model.
module tb_ddr_rd_arbiter;
   logic       clk, rst;
   logic [1:0] err_flags;
   ddr_rd_arbiter_if bus();
   ddr_rd_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .err_flags(err_flags));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  reqs;
      logic [31:0] addr;
      logic [7:0]  lf;
      int          rdly;
      int          lastpos;
      bit          garb;
      int          eg;
      logic [31:0] ea;
      logic [8:0]  el;
      logic [1:0]  eerr;
   } vec_t;

   int   n_chk = 0, n_pass = 0;
   int   mrr = 0, gcl = 0;
   bit   garb_on = 0, drop_on = 0;
   logic [1:0] merr = 2'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (garb_on)
         for (int i = 0; i < 4; i++)
            if (i != gcl) begin
               bus.cl_vout[i] = 1'($urandom);
               bus.cl_dout[i*32 +: 32] = $urandom;
            end
   endtask

   task automatic reset_abort();
      rst = 1'b1;
      #1;
      chk("rst_ack", 32'(bus.cl_ack), 0);
      chk("rst_vin", 32'(bus.cl_vin), 0);
      chk("rst_din", bus.cl_din, 0);
      chk("rst_cmd_valid", 32'(bus.m_cmd_valid), 0);
      chk("rst_addr", bus.m_cmd_addr, 0);
      chk("rst_len", 32'(bus.m_cmd_len), 0);
      chk("rst_err", 32'(err_flags), 0);
      garb_on = 0;
      bus.cl_vout = '0;
      bus.cl_req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.m_rd_valid = 1'b1;
         bus.m_rd_data = $urandom;
         tick();
         chk("stale_beat_vin", 32'(bus.cl_vin), 0);
      end
      bus.m_rd_valid = 1'b0;
      mrr = 0;
      merr = 2'b0;
   endtask

   task automatic serve(input logic [3:0] reqs, input logic [31:0] a, input logic [7:0] lf,
                        input int rdly, input int lastpos, input bit garb, input int abort,
                        input int eg, input logic [31:0] ea, input logic [8:0] el);
      logic [3:0]  oh;
      logic [31:0] d;
      int          n;
      oh = 4'b1 << eg;
      n = int'(el);
      bus.cl_req = reqs;
      tick();
      chk("grant", 32'(bus.cl_ack), 32'(oh));
      if (drop_on) bus.cl_req[eg] = 1'b0;
      gcl = eg;
      garb_on = garb;
      bus.cl_vout[eg] = 1'b1;
      bus.cl_dout[eg*32 +: 32] = a;
      tick();
      chk("cmd_not_early", 32'(bus.m_cmd_valid), 0);
      bus.cl_dout[eg*32 +: 32] = {24'($urandom), lf};
      tick();
      bus.cl_vout[eg] = 1'b0;
      chk("cmd_valid", 32'(bus.m_cmd_valid), 1);
      chk("cmd_addr", bus.m_cmd_addr, ea);
      chk("cmd_len", 32'(bus.m_cmd_len), 32'(el));
      for (int i = 0; i < rdly; i++) begin
         tick();
         chk("hold_valid", 32'(bus.m_cmd_valid), 1);
         chk("hold_addr", bus.m_cmd_addr, ea);
         chk("hold_len", 32'(bus.m_cmd_len), 32'(el));
      end
      bus.m_cmd_ready = 1'b1;
      tick();
      bus.m_cmd_ready = 1'b0;
      chk("cmd_taken", 32'(bus.m_cmd_valid), 0);
      for (int b = 0; b < n; b++) begin
         if (b == abort) begin
            reset_abort();
            return;
         end
         repeat ($urandom_range(0, 2)) begin
            tick();
            chk("gap_vin", 32'(bus.cl_vin), 0);
         end
         d = $urandom;
         bus.m_rd_valid = 1'b1;
         bus.m_rd_data = d;
         bus.m_rd_last = (b == lastpos);
         tick();
         bus.m_rd_valid = 1'b0;
         bus.m_rd_last = 1'b0;
         chk("beat_vin", 32'(bus.cl_vin), 32'(oh));
         chk("beat_din", bus.cl_din, d);
         chk("beat_ack", 32'(bus.cl_ack), (b == n - 1) ? 0 : 32'(oh));
      end
      garb_on = 0;
      bus.cl_vout = '0;
      tick();
      chk("idle_ack", 32'(bus.cl_ack), 0);
   endtask

   vec_t tab[9];

   initial begin
      logic [3:0]  reqs;
      logic [31:0] a;
      logic [7:0]  lf;
      logic [8:0]  el;
      int          w, lp;
      tab[0] = '{4'hf, 32'h2000_0011, 8'h01, 0, 0, 1'b0, 0, 32'h2000_0010, 9'd1, 2'd0};
      tab[1] = '{4'hf, 32'h2000_0122, 8'h01, 0, 0, 1'b0, 1, 32'h2000_0120, 9'd1, 2'd0};
      tab[2] = '{4'hf, 32'h2000_0233, 8'h01, 0, 0, 1'b0, 2, 32'h2000_0230, 9'd1, 2'd0};
      tab[3] = '{4'hf, 32'h2000_0344, 8'h01, 0, 0, 1'b0, 3, 32'h2000_0344, 9'd1, 2'd0};
      tab[4] = '{4'hf, 32'h2000_0455, 8'h01, 0, 0, 1'b0, 0, 32'h2000_0454, 9'd1, 2'd0};
      tab[5] = '{4'b0010, 32'h1000_0003, 8'h04, 0, 3, 1'b0, 1, 32'h1000_0000, 9'd4, 2'd0};
      tab[6] = '{4'b0100, 32'h3000_0ab6, 8'h03, 2, 2, 1'b1, 2, 32'h3000_0ab4, 9'd3, 2'd0};
      tab[7] = '{4'b1000, 32'h4000_0000, 8'h00, 10, 255, 1'b0, 3, 32'h4000_0000, 9'd256, 2'd0};
      tab[8] = '{4'b0001, 32'h5000_0008, 8'h04, 1, 1, 1'b0, 0, 32'h5000_0008, 9'd4, 2'd1};
      rst = 1'b1;
      bus.cl_req = '0;
      bus.cl_vout = '0;
      bus.cl_dout = '0;
      bus.m_cmd_ready = 1'b0;
      bus.m_rd_valid = 1'b0;
      bus.m_rd_data = '0;
      bus.m_rd_last = 1'b0;
      tick();
      chk("init_ack", 32'(bus.cl_ack), 0);
      chk("init_vin", 32'(bus.cl_vin), 0);
      chk("init_cmd_valid", 32'(bus.m_cmd_valid), 0);
      chk("init_addr", bus.m_cmd_addr, 0);
      chk("init_err", 32'(err_flags), 0);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 9; i++) begin
         serve(tab[i].reqs, tab[i].addr, tab[i].lf, tab[i].rdly, tab[i].lastpos, tab[i].garb,
               -1, tab[i].eg, tab[i].ea, tab[i].el);
         chk("vec_err", 32'(err_flags), 32'(tab[i].eerr));
      end
      serve(4'b0010, 32'h6000_0000, 8'h08, 0, 7, 1'b0, 2, 1, 32'h6000_0000, 9'd8);
      serve(4'hf, 32'h7000_0004, 8'h02, 0, 1, 1'b0, -1, 0, 32'h7000_0004, 9'd2);
      chk("post_rst_err", 32'(err_flags), 0);
      mrr = 1;
      for (int t = 0; t < 30; t++) begin
         reqs = 4'($urandom_range(1, 15));
         w = pick(reqs, mrr);
         a = $urandom;
         lf = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
         el = (lf == 8'd0) ? 9'd256 : {1'b0, lf};
         lp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(el)) : int'(el) - 1;
         drop_on = 1'($urandom);
         serve(reqs, a, lf, $urandom_range(0, 3), lp, 1'($urandom), -1, w, a & ~32'h3, el);
         drop_on = 0;
         mrr = (w + 1) % 4;
         if (lp != int'(el) - 1) merr[0] = 1'b1;
         chk("rand_err", 32'(err_flags), 32'(merr));
      end
`ifdef DDR_RD_ARB_TIMEOUT_EN
      bus.cl_req = 4'b0100;
      w = pick(4'b0100, mrr);
      tick();
      bus.cl_req = '0;
      chk("tmo_grant", 32'(bus.cl_ack), 32'(4'b1 << w));
      for (int i = 1; i < 256; i++) begin
         tick();
         chk("tmo_hold_ack", 32'(bus.cl_ack), 32'(4'b1 << w));
         chk("tmo_no_cmd", 32'(bus.m_cmd_valid), 0);
      end
      tick();
      chk("tmo_ack_drop", 32'(bus.cl_ack), 0);
      chk("tmo_no_cmd_end", 32'(bus.m_cmd_valid), 0);
      chk("tmo_err", 32'(err_flags[1]), 1);
      mrr = (w + 1) % 4;
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Four-client round-robin arbiter for the DVP DDR read path. It sits directly upstream of each stage's DDR Read Arbiter I/F (rect, gftt, and the other consumers) and serialises their read requests onto one DDR read master. It accepts an address/length command from the granted client and forwards the returned beats back to that client only.

## Interface
- Parameters: none. Client count is fixed at 4, length field at 8 bits, timeout at 256 cycles.
- clk  in  1  system clock
- rst  in  1  **asynchronous, active-high reset**
- cl_req  in  4  per-client request, bit i = client i (client drd_req)
- cl_ack  out  4  per-client grant, one-hot or zero (client drd_ack)
- cl_vout  in  4  per-client command-word valid (client drd_vout)
- cl_dout  in  128  command words, client i on bits [32i+31:32i] (client drd_dout)
- cl_vin  out  4  per-client read-data valid, one-hot or zero (client drd_vin)
- cl_din  out  32  read data, broadcast to all clients; qualified by cl_vin
- m_cmd_valid  out  1  DDR read command valid
- m_cmd_ready  in  1  DDR master accepts command
- m_cmd_addr  out  32  byte address, bits [1:0] forced 0
- m_cmd_len  out  9  beat count, 1..256
- m_rd_valid  in  1  read beat valid; no backpressure, always accepted
- m_rd_data  in  32  read beat
- m_rd_last  in  1  final beat marker from master
- err_flags  out  2  sticky: [0] last-mismatch, [1] command timeout

## Operation
- FSM states: IDLE, ADDR, LEN, CMD, DATA, DONE.
- IDLE: if any cl_req bit is set, pick the first set bit searching upward from rr_ptr, with wrap 3->0. Set the matching cl_ack bit and go to ADDR. rr_ptr becomes winner+1 mod 4.
- ADDR: on cl_vout[g], latch cl_dout word g as the address, with bits [1:0] cleared. Go to LEN.
- LEN: on cl_vout[g], take bits [7:0] of the word as the length. A value of 0 means 256 beats. Go to CMD.
- cl_vout from non-granted clients is ignored in every state. cl_vout[g] outside ADDR/LEN is also ignored.
- CMD: hold m_cmd_valid=1 with stable addr/len until m_cmd_ready is sampled high. Then go to DATA with the beat counter set to len.
- DATA: each m_rd_valid is forwarded to cl_vin[g]/cl_din and decrements the counter.
  - When the counter reaches 0, go to DONE.
  - If m_rd_last is set on a beat other than the final counted beat, or is clear on the final beat, set err_flags[0]. The counter governs termination in both cases.
- DONE: clear cl_ack for one cycle, then go to IDLE. The client must drop cl_req by this cycle. A req still high competes again in IDLE at lowest priority for that client.
- A client dropping cl_req while granted is ignored. The transaction runs to completion.
- err_flags is cleared only by rst.

## Timing
- Reset values: cl_ack=0, cl_vin=0, cl_din=0, m_cmd_valid=0, m_cmd_addr=0, m_cmd_len=0, err_flags=0, rr_ptr=0, state IDLE.
- Reset mid-transaction aborts immediately. Any beats still outstanding at the master after reset are dropped by IDLE/ADDR/LEN/CMD, which do not forward m_rd_valid.
- Grant latency: cl_ack rises 1 cycle after cl_req is sampled high in IDLE.
- Earliest command: cl_vout words may arrive in the two cycles after cl_ack rises. m_cmd_valid rises the cycle after the LEN word.
- Data latency: cl_vin/cl_din are registered, 1 cycle after m_rd_valid/m_rd_data.
- cl_ack falls 1 cycle after the final beat is sampled, the same cycle cl_vin shows that beat.
- Minimum gap between grants: 2 cycles (DONE, IDLE).
- All outputs are registered.

## Configuration
- DDR_RD_ARB_TIMEOUT_EN defined:
  - A 8-bit counter runs in ADDR and LEN and resets on each accepted command word.
  - On reaching 255 with no cl_vout[g], the arbiter goes to DONE without issuing a command and sets err_flags[1].
- Undefined: no counter. ADDR/LEN wait indefinitely, and err_flags[1] is tied to 0.

## Test plan
- Single transfer: client 1 requests, sends addr 0x1000_0003 then len 4, master returns 4 beats with last on the 4th.
  - m_cmd_addr=0x1000_0000, m_cmd_len=4.
  - cl_vin[1] pulses 4 times and cl_ack[1] falls with the 4th.
  - err_flags=0.
- Round-robin: all 4 clients request continuously with len 1 each. Grant order is 0,1,2,3,0, and no client is granted twice in a row.
- Len 0 with m_cmd_ready held low 10 cycles: m_cmd_valid and addr stay stable for 10 cycles, then m_cmd_len=256 and 256 beats are delivered.
- Last mismatch: len 4 with m_rd_last on beat 2. err_flags[0]=1, all 4 beats are forwarded, and ack falls after beat 4.
- Isolation: client 2 granted, client 0 toggles cl_vout with garbage. The command uses client 2 words only, and cl_vin[0] stays 0.
- Reset and timeout:
  - Reset asserted mid-DATA after 2 of 8 beats: all outputs are 0 the same cycle, and the next grant goes to client 0 first.
  - With DDR_RD_ARB_TIMEOUT_EN, a grant with no cl_vout for 256 cycles drops ack, sets err_flags[1]=1 and never asserts m_cmd_valid.
